// File: rtl/prefix_sub_if.sv
// Operand/result handshake bundle for prefix_sub.
// The op port exists only when PREFIX_SUB_ADD_MODE_EN is defined.
interface prefix_sub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             bin;
`ifdef PREFIX_SUB_ADD_MODE_EN
   logic             op;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             zero;
   logic             ovf;
   logic             lt_u;
   logic             lt_s;

   modport master (
`ifdef PREFIX_SUB_ADD_MODE_EN
      output op,
`endif
      output in_valid, x, y, bin, out_ready,
      input  in_ready, out_valid, d, bout, zero, ovf, lt_u, lt_s
   );

   modport slave (
`ifdef PREFIX_SUB_ADD_MODE_EN
      input  op,
`endif
      input  in_valid, x, y, bin, out_ready,
      output in_ready, out_valid, d, bout, zero, ovf, lt_u, lt_s
   );
endinterface

// File: rtl/prefix_sub.sv
// Pipelined Kogge-Stone subtractor/comparator with valid/ready and a global stall.
// Define PREFIX_SUB_ADD_MODE_EN to add the op input (op=1 selects add).
module prefix_sub #(
   parameter int WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   prefix_sub_if.slave bus
);
   localparam int LEVELS = $clog2(WIDTH);

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] a;
   } ga_t;

   // One Kogge-Stone level: combine each bit with the group 'span' bits below it.
   function automatic ga_t prefix_level(input ga_t cur, input int span);
      ga_t nxt;
      nxt = cur;
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= span) begin
            nxt.g[i] = cur.g[i] | (cur.a[i] & cur.g[i-span]);
            nxt.a[i] = cur.a[i] & cur.a[i-span];
         end
      end
      return nxt;
   endfunction

   logic             vld_p [0:LEVELS+1];
   logic [WIDTH-1:0] p_p   [0:LEVELS];
   ga_t              ga_p  [0:LEVELS];
   logic             c0_p  [0:LEVELS];
   logic             xm_p  [0:LEVELS];
   logic             ym_p  [0:LEVELS];
   logic             op_p  [0:LEVELS];

   logic [WIDTH-1:0] d_q;
   logic             bout_q, zero_q, ovf_q, lt_u_q, lt_s_q;

   logic             stall;
   logic             op_in;
   logic [WIDTH-1:0] yy;
   ga_t              ga_nxt [1:LEVELS];
   ga_t              ga_fold;
   logic [WIDTH-1:0] carries, d_n;
   logic             cout, bout_n, ovf_n;

`ifdef PREFIX_SUB_ADD_MODE_EN
   assign op_in = bus.op;
`else
   assign op_in = 1'b0;
`endif

   assign stall         = vld_p[LEVELS+1] & ~bus.out_ready;
   assign bus.in_ready  = ~stall;
   assign bus.out_valid = vld_p[LEVELS+1];
   assign bus.d         = d_q;
   assign bus.bout      = bout_q;
   assign bus.zero      = zero_q;
   assign bus.ovf       = ovf_q;
   assign bus.lt_u      = lt_u_q;
   assign bus.lt_s      = lt_s_q;

   // Subtract runs as x + ~y + ~bin; add mode bypasses both inversions.
   assign yy = op_in ? bus.y : ~bus.y;

   always_comb begin
      ga_fold      = ga_p[0];
      ga_fold.g[0] = ga_p[0].g[0] | (ga_p[0].a[0] & c0_p[0]);
      for (int k = 1; k <= LEVELS; k++) begin
         ga_nxt[k] = prefix_level((k == 1) ? ga_fold : ga_p[k-1], 1 << (k - 1));
      end
   end

   // Final stage: the MSB carry-out is rebuilt from the carried operand MSBs.
   always_comb begin
      carries = {ga_p[LEVELS].g[WIDTH-2:0], c0_p[LEVELS]};
      d_n     = p_p[LEVELS] ^ carries;
      cout    = (xm_p[LEVELS] & ym_p[LEVELS]) |
                ((xm_p[LEVELS] | ym_p[LEVELS]) & carries[WIDTH-1]);
      bout_n  = op_p[LEVELS] ? cout : ~cout;
      ovf_n   = carries[WIDTH-1] ^ cout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= LEVELS + 1; k++) vld_p[k] <= 1'b0;
         for (int k = 0; k <= LEVELS; k++) begin
            p_p[k]  <= '0;
            ga_p[k] <= '0;
            c0_p[k] <= 1'b0;
            xm_p[k] <= 1'b0;
            ym_p[k] <= 1'b0;
            op_p[k] <= 1'b0;
         end
         d_q    <= '0;
         bout_q <= 1'b0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
         lt_u_q <= 1'b0;
         lt_s_q <= 1'b0;
      end else if (!stall) begin
         // Stage 0: bitwise propagate/generate/alive and carry-in
         vld_p[0]  <= bus.in_valid;
         p_p[0]    <= bus.x ^ yy;
         ga_p[0].g <= bus.x & yy;
         ga_p[0].a <= (bus.x & yy) | (bus.x ^ yy);
         c0_p[0]   <= op_in ? bus.bin : ~bus.bin;
         xm_p[0]   <= bus.x[WIDTH-1];
         ym_p[0]   <= yy[WIDTH-1];
         op_p[0]   <= op_in;
         // Stages 1..LEVELS: one prefix level each
         for (int k = 1; k <= LEVELS; k++) begin
            vld_p[k] <= vld_p[k-1];
            p_p[k]   <= p_p[k-1];
            ga_p[k]  <= ga_nxt[k];
            c0_p[k]  <= c0_p[k-1];
            xm_p[k]  <= xm_p[k-1];
            ym_p[k]  <= ym_p[k-1];
            op_p[k]  <= op_p[k-1];
         end
         // Output stage: difference and flags
         vld_p[LEVELS+1] <= vld_p[LEVELS];
         d_q    <= d_n;
         bout_q <= bout_n;
         zero_q <= (d_n == '0);
         ovf_q  <= ovf_n;
         lt_u_q <= op_p[LEVELS] ? 1'b0 : bout_n;
         lt_s_q <= op_p[LEVELS] ? 1'b0 : (d_n[WIDTH-1] ^ ovf_n);
      end
   end
endmodule

// File: tb/tb_prefix_sub.sv
// Directed bench for prefix_sub: vector table, back-pressure stream, mid-stream reset.
module tb_prefix_sub;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prefix_sub_if #(.WIDTH(W)) sif ();

   prefix_sub #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         bin;
      logic         op;
      logic [W-1:0] d;
      logic         bout, zero, ovf, lt_u, lt_s;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin,
                        input logic op, input logic vld);
      sif.x        = x;
      sif.y        = y;
      sif.bin      = bin;
      sif.in_valid = vld;
`ifdef PREFIX_SUB_ADD_MODE_EN
      sif.op       = op;
`else
      if (op) $display("note: op ignored in subtract-only build");
`endif
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      int cnt;
      bit got;
      @(negedge clk);
      drive(v.x, v.y, v.bin, v.op, 1'b1);
      sif.out_ready = 1'b1;
      @(negedge clk);
      sif.in_valid = 1'b0;
      cnt = 0;
      got = 0;
      while (cnt < 20 && !got) begin
         if (sif.out_valid) got = 1;
         else begin
            @(negedge clk);
            cnt++;
         end
      end
      if (!got) begin
         chk({nm, " timeout"}, 64'(cnt), 64'd6);
      end else begin
         chk({nm, " latency"}, 64'(cnt), 64'd6);
         chk({nm, " d"},    64'(sif.d),    64'(v.d));
         chk({nm, " bout"}, 64'(sif.bout), 64'(v.bout));
         chk({nm, " zero"}, 64'(sif.zero), 64'(v.zero));
         chk({nm, " ovf"},  64'(sif.ovf),  64'(v.ovf));
         chk({nm, " lt_u"}, 64'(sif.lt_u), 64'(v.lt_u));
         chk({nm, " lt_s"}, 64'(sif.lt_s), 64'(v.lt_s));
      end
   endtask

   initial begin
      logic [W-1:0] sx[8], sy[8], sd[8];
      logic         sb[8];
      int           sent, rcv, stalls, cyc, stale;

      //               x             y             bin op  d             bo z  ov lu ls
      vecs.push_back('{32'd5,        32'd3,        0, 0, 32'd2,        0, 0, 0, 0, 0});
      vecs.push_back('{32'd0,        32'd1,        0, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1});
      vecs.push_back('{32'h80000000, 32'd1,        0, 0, 32'h7FFFFFFF, 0, 0, 1, 0, 1});
      vecs.push_back('{32'h1234,     32'h1234,     1, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1});
      vecs.push_back('{32'h1234,     32'h1234,     0, 0, 32'd0,        0, 1, 0, 0, 0});
      vecs.push_back('{32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h80000000, 1, 0, 1, 1, 0});
      vecs.push_back('{32'd0,        32'd0,        1, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1});
      vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 1});
`ifdef PREFIX_SUB_ADD_MODE_EN
      vecs.push_back('{32'hFFFFFFFF, 32'd1,        0, 1, 32'd0,        1, 1, 0, 0, 0});
      vecs.push_back('{32'h7FFFFFFF, 32'd1,        0, 1, 32'h80000000, 0, 0, 1, 0, 0});
      vecs.push_back('{32'd5,        32'd3,        1, 1, 32'd9,        0, 0, 0, 0, 0});
`endif

      drive('0, '0, 1'b0, 1'b0, 1'b0);
      sif.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset out_valid", 64'(sif.out_valid), 64'd0);
      chk("reset in_ready",  64'(sif.in_ready),  64'd1);
      chk("reset d",         64'(sif.d),         64'd0);
      chk("reset flags", 64'({sif.bout, sif.zero, sif.ovf, sif.lt_u, sif.lt_s}), 64'd0);

      for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Back-to-back stream with a 3-cycle stall once the first result shows up
      for (int i = 0; i < 8; i++) begin
         sx[i] = 32'd100 + 32'(i * 7);
         sy[i] = 32'(i * 29);
         sb[i] = i[0];
         sd[i] = sx[i] - sy[i] - 32'(sb[i]);
      end
      sent = 0; rcv = 0; stalls = 0; cyc = 0;
      while (rcv < 8 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (sif.out_valid && stalls < 3) begin
            sif.out_ready = 1'b0;
            stalls++;
         end else sif.out_ready = 1'b1;
         if (sent < 8) drive(sx[sent], sy[sent], sb[sent], 1'b0, 1'b1);
         else sif.in_valid = 1'b0;
         #1;
         if (sif.out_valid && !sif.out_ready) begin
            chk($sformatf("stall in_ready c%0d", cyc), 64'(sif.in_ready), 64'd0);
            chk($sformatf("stall d hold c%0d", cyc), 64'(sif.d), 64'(sd[rcv]));
         end
         if (sif.in_valid && sif.in_ready) sent++;
         if (sif.out_valid && sif.out_ready) begin
            chk($sformatf("stream d%0d", rcv), 64'(sif.d), 64'(sd[rcv]));
            rcv++;
         end
      end
      chk("stream count", 64'(rcv), 64'd8);
      sif.in_valid = 1'b0;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (sif.out_valid) stale++;
      end
      chk("stream no extras", 64'(stale), 64'd0);

      // Reset with 4 ops in flight; in_valid held high during reset must be ignored
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(32'd50 + 32'(i), 32'd1, 1'b0, 1'b0, 1'b1);
      end
      @(negedge clk);
      drive(32'd99, 32'd1, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sif.in_valid = 1'b0;
      chk("midreset out_valid", 64'(sif.out_valid), 64'd0);
      chk("midreset in_ready",  64'(sif.in_ready),  64'd1);
      stale = 0;
      repeat (12) begin
         @(negedge clk);
         if (sif.out_valid) stale++;
      end
      chk("midreset no stale", 64'(stale), 64'd0);
      run_vec("post-reset", '{32'd10, 32'd4, 0, 0, 32'd6, 0, 0, 0, 0, 0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
